// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C byte engine between NREQ requesters.
// The winner's byte count and payload are latched at grant time. The engine
// completion is routed back only to the granted requester.
// Optional macro I2C_ARB_TIMEOUT_EN adds a WAIT-state watchdog that pulses
// err_o after TIMEOUT-1 cycles. Without the macro, err_o is tied low.
module i2c_arbiter #(
    parameter int NREQ    = 3,
    parameter int NBYTES  = 3,
    parameter int TIMEOUT = 2000000
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NREQ-1:0]                   req_i,
    input  logic [NREQ*$clog2(NBYTES)-1:0]    nbytes_i,
    input  logic [NREQ*NBYTES*8-1:0]          data_i,
    output logic [NREQ-1:0]                   grant_o,
    output logic [NREQ-1:0]                   done_o,
    output logic [NREQ-1:0]                   err_o,
    input  logic                              eng_ready_i,
    input  logic                              eng_done_i,
    output logic                              eng_send_o,
    output logic [$clog2(NBYTES)-1:0]         eng_nbytes_o,
    output logic [NBYTES*8-1:0]               eng_data_o
);

    localparam int                 IW  = $clog2(NREQ);
    localparam int                 NBW = $clog2(NBYTES);
    localparam int                 DW  = NBYTES * 8;
    localparam int unsigned        NR  = NREQ;
    localparam logic [NREQ-1:0]    ONE = NREQ'(1);

    if (NREQ < 2 || TIMEOUT < 2) begin : g_param_check
        $error("i2c_arbiter: NREQ and TIMEOUT must both be >= 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NREQ-1:0] grant_d, done_d;
    logic            send_d;
    logic [NBW-1:0]  nbytes_d;
    logic [DW-1:0]   data_d;
    logic            pick_valid;
    logic [IW-1:0]   pick;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int   CW = $clog2(TIMEOUT);
    logic [CW-1:0]   tmo_q;
    logic            tmo_hit;
    logic [NREQ-1:0] err_d;

    // The counter reads TIMEOUT-1 in the cycle err_o is visible, so the
    // decision is taken one count earlier.
    assign tmo_hit = (tmo_q == CW'(TIMEOUT - 2));

    // Watchdog counter: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == ISSUE)
            tmo_q <= '0;
        else if (state_q == WAIT)
            tmo_q <= tmo_q + CW'(1);
    end
`else
    assign err_o = '0;
`endif

    // Rotating-priority pick: first request scanning last+1, last+2, ... mod NREQ
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] idx_w;
        pick_valid = 1'b0;
        pick       = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx   = (32'(last_q) + i) % NR;
            idx_w = IW'(idx);
            if (!pick_valid && req_i[idx_w]) begin
                pick_valid = 1'b1;
                pick       = idx_w;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        grant_d  = grant_o;
        done_d   = '0;
        send_d   = 1'b0;
        nbytes_d = eng_nbytes_o;
        data_d   = eng_data_o;
`ifdef I2C_ARB_TIMEOUT_EN
        err_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (eng_ready_i && pick_valid) begin
                    win_d    = pick;
                    grant_d  = ONE << pick;
                    nbytes_d = nbytes_i[pick*NBW +: NBW];
                    data_d   = data_i[pick*DW +: DW];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                send_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done_i) begin
                    done_d  = ONE << win_q;
                    last_d  = win_q;
                    state_d = RELEASE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = ONE << win_q;
                    last_d  = win_q;
                    state_d = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (eng_ready_i) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Registered outputs, round-robin pointer and current winner
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= IW'(NREQ - 1);
            win_q        <= '0;
            grant_o      <= '0;
            done_o       <= '0;
            eng_send_o   <= 1'b0;
            eng_nbytes_o <= '0;
            eng_data_o   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_o        <= '0;
`endif
        end else begin
            last_q       <= last_d;
            win_q        <= win_d;
            grant_o      <= grant_d;
            done_o       <= done_d;
            eng_send_o   <= send_d;
            eng_nbytes_o <= nbytes_d;
            eng_data_o   <= data_d;
`ifdef I2C_ARB_TIMEOUT_EN
            err_o        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: a cycle table plus engine-model sequences.
// With I2C_ARB_TIMEOUT_EN defined, it also checks the WAIT watchdog (TIMEOUT=50).
module tb_i2c_arbiter;

    localparam int NREQ       = 3;
    localparam int NBYTES     = 3;
    localparam int TB_TIMEOUT = 50;

    localparam logic [5:0]  NB0 = {2'd3, 2'd1, 2'd2};
    localparam logic [71:0] D0  = {24'hCCCCCC, 24'hBBBBBB, 24'h720835};
    localparam logic [71:0] D1  = {24'h111111, 24'h222222, 24'h333333};

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  req_i;
    logic [5:0]  nbytes_i;
    logic [71:0] data_i;
    logic [2:0]  grant_o, done_o, err_o;
    logic        eng_ready_i, eng_done_i, eng_send_o;
    logic [1:0]  eng_nbytes_o;
    logic [23:0] eng_data_o;

    // Free-running clock
    always #5 clk_i = ~clk_i;

    i2c_arbiter #(
        .NREQ   (NREQ),
        .NBYTES (NBYTES),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .nbytes_i    (nbytes_i),
        .data_i      (data_i),
        .grant_o     (grant_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .eng_ready_i (eng_ready_i),
        .eng_done_i  (eng_done_i),
        .eng_send_o  (eng_send_o),
        .eng_nbytes_o(eng_nbytes_o),
        .eng_data_o  (eng_data_o)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        rdy;
        logic        dn;
        logic [71:0] data;
        logic [2:0]  eg;
        logic [2:0]  ed;
        logic        es;
        logic [1:0]  enb;
        logic [23:0] edat;
    } vec_t;

    vec_t        vecs[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          sends, onehot_bad;
    int          dones[3];
    int          errs[3];
    int          order_q[$];
    logic [23:0] send_data;
    logic [1:0]  send_nb;
    logic        eng_auto;
    int          eng_lat, eng_busy;
    logic [2:0]  drop_mask;

    function automatic int gidx(input logic [2:0] g);
        for (int k = 0; k < 3; k++)
            if (g[k]) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [2:0] req, input logic rdy, input logic dn,
                       input logic [71:0] data, input logic [2:0] eg, input logic [2:0] ed,
                       input logic es, input logic [1:0] enb, input logic [23:0] edat);
        vec_t v;
        v.rst = rst; v.req = req; v.rdy = rdy; v.dn = dn; v.data = data;
        v.eg = eg; v.ed = ed; v.es = es; v.enb = enb; v.edat = edat;
        vecs.push_back(v);
    endtask

    task automatic clear_stats();
        sends = 0; onehot_bad = 0; order_q.delete();
        for (int k = 0; k < 3; k++) begin
            dones[k] = 0;
            errs[k]  = 0;
        end
    endtask

    // One clock: sample after the edge, then update requesters and engine model
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (!$onehot0(grant_o)) onehot_bad++;
        if (eng_send_o) begin
            sends++;
            order_q.push_back(gidx(grant_o));
            send_data = eng_data_o;
            send_nb   = eng_nbytes_o;
        end
        for (int k = 0; k < 3; k++) begin
            if (done_o[k]) dones[k]++;
            if (err_o[k])  errs[k]++;
        end
        req_i = req_i & ~(done_o & drop_mask);
        if (eng_auto) begin
            eng_done_i = 1'b0;
            if (eng_send_o) begin
                eng_ready_i = 1'b0;
                eng_busy    = eng_lat;
            end else if (eng_busy > 0) begin
                eng_busy--;
                if (eng_busy == 0) begin
                    eng_done_i  = 1'b1;
                    eng_ready_i = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_i = '0; eng_auto = 1'b0; eng_ready_i = 1'b1;
        eng_done_i = 1'b0; eng_busy = 0; drop_mask = '0; data_i = D0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int k_err;
        logic [2:0] err_val, grant_after;
        nbytes_i = NB0;
        clear_stats();
        do_reset();
        chk("reset grant", grant_o, 3'b000);
        chk("reset done", done_o, 3'b000);
        chk("reset err", err_o, 3'b000);
        chk("reset send", eng_send_o, 1'b0);
        chk("reset nbytes", eng_nbytes_o, 2'd0);
        chk("reset data", eng_data_o, 24'h0);

        //   rst  req    rdy   dn    data  grant  done   send  nb    data
        add(1'b0, 3'b000, 1'b1, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd0, 24'h000000);
        add(1'b0, 3'b010, 1'b0, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd0, 24'h000000);
        add(1'b0, 3'b010, 1'b0, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd0, 24'h000000);
        add(1'b0, 3'b010, 1'b1, 1'b0, D0, 3'b010, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b010, 1'b0, 1'b0, D1, 3'b010, 3'b000, 1'b1, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b000, 1'b0, 1'b0, D1, 3'b010, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b000, 1'b1, 1'b1, D0, 3'b010, 3'b010, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b000, 1'b1, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b000, 1'b1, 1'b1, D0, 3'b000, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b101, 1'b1, 1'b0, D0, 3'b100, 3'b000, 1'b0, 2'd3, 24'hCCCCCC);
        add(1'b0, 3'b101, 1'b0, 1'b0, D0, 3'b100, 3'b000, 1'b1, 2'd3, 24'hCCCCCC);
        add(1'b0, 3'b101, 1'b0, 1'b0, D0, 3'b100, 3'b000, 1'b0, 2'd3, 24'hCCCCCC);
        add(1'b0, 3'b001, 1'b0, 1'b1, D0, 3'b100, 3'b100, 1'b0, 2'd3, 24'hCCCCCC);
        add(1'b0, 3'b001, 1'b0, 1'b0, D0, 3'b100, 3'b000, 1'b0, 2'd3, 24'hCCCCCC);
        add(1'b0, 3'b001, 1'b1, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd3, 24'hCCCCCC);
        add(1'b0, 3'b001, 1'b1, 1'b0, D0, 3'b001, 3'b000, 1'b0, 2'd2, 24'h720835);
        add(1'b0, 3'b001, 1'b1, 1'b0, D0, 3'b001, 3'b000, 1'b1, 2'd2, 24'h720835);
        add(1'b0, 3'b000, 1'b0, 1'b0, D0, 3'b001, 3'b000, 1'b0, 2'd2, 24'h720835);
        add(1'b0, 3'b000, 1'b0, 1'b1, D0, 3'b001, 3'b001, 1'b0, 2'd2, 24'h720835);
        add(1'b0, 3'b110, 1'b1, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd2, 24'h720835);
        add(1'b0, 3'b110, 1'b1, 1'b0, D0, 3'b010, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b110, 1'b0, 1'b0, D0, 3'b010, 3'b000, 1'b1, 2'd1, 24'hBBBBBB);
        add(1'b1, 3'b110, 1'b0, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd0, 24'h000000);
        add(1'b0, 3'b110, 1'b1, 1'b1, D0, 3'b010, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b110, 1'b0, 1'b0, D0, 3'b010, 3'b000, 1'b1, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b100, 1'b0, 1'b1, D0, 3'b010, 3'b010, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b100, 1'b1, 1'b0, D0, 3'b000, 3'b000, 1'b0, 2'd1, 24'hBBBBBB);
        add(1'b0, 3'b100, 1'b1, 1'b0, D0, 3'b100, 3'b000, 1'b0, 2'd3, 24'hCCCCCC);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i = vecs[i].rst; req_i = vecs[i].req; eng_ready_i = vecs[i].rdy;
            eng_done_i = vecs[i].dn; data_i = vecs[i].data;
            tick();
            chk($sformatf("v%0d grant", i), grant_o, vecs[i].eg);
            chk($sformatf("v%0d done", i), done_o, vecs[i].ed);
            chk($sformatf("v%0d send", i), eng_send_o, vecs[i].es);
            chk($sformatf("v%0d nbytes", i), eng_nbytes_o, vecs[i].enb);
            chk($sformatf("v%0d data", i), eng_data_o, vecs[i].edat);
            chk($sformatf("v%0d err", i), err_o, 3'b000);
        end

        // Single requester, engine finishes 100 cycles after the send
        do_reset();
        clear_stats();
        eng_auto = 1'b1; eng_lat = 100; drop_mask = 3'b001; req_i = 3'b001;
        tick();
        chk("single grant latency", grant_o, 3'b001);
        chk("single no early send", eng_send_o, 1'b0);
        tick();
        chk("single send latency", eng_send_o, 1'b1);
        repeat (128) tick();
        chk("single sends", sends, 1);
        chk("single data", send_data, 24'h720835);
        chk("single nbytes", send_nb, 2'd2);
        chk("single done0", dones[0], 1);
        chk("single done others", dones[1] + dones[2], 0);
        chk("single grant idle", grant_o, 3'b000);

        // Contention: all three request at once, each drops after its done
        do_reset();
        clear_stats();
        eng_auto = 1'b1; eng_lat = 5; drop_mask = 3'b111; req_i = 3'b111;
        repeat (60) tick();
        chk("contend sends", sends, 3);
        chk("contend onehot", onehot_bad, 0);
        chk("contend order count", order_q.size() >= 3, 1'b1);
        for (int k = 0; k < 3 && k < order_q.size(); k++)
            chk($sformatf("contend order %0d", k), order_q[k], k);
        for (int k = 0; k < 3; k++)
            chk($sformatf("contend done%0d", k), dones[k], 1);
        chk("contend grant idle", grant_o, 3'b000);

        // Fairness: requesters 0 and 2 held high continuously
        do_reset();
        clear_stats();
        eng_auto = 1'b1; eng_lat = 5; drop_mask = 3'b000; req_i = 3'b101;
        repeat (50) tick();
        chk("fair order count", order_q.size() >= 4, 1'b1);
        for (int k = 0; k < 4 && k < order_q.size(); k++)
            chk($sformatf("fair order %0d", k), order_q[k], (k % 2 == 0) ? 0 : 2);
        chk("fair onehot", onehot_bad, 0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: engine never completes
        do_reset();
        clear_stats();
        eng_ready_i = 1'b1; eng_done_i = 1'b0; req_i = 3'b010;
        tick();
        tick();
        chk("tmo send", eng_send_o, 1'b1);
        k_err = -1; err_val = '0; grant_after = 3'b111;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == k_err + 1 && k_err > 0) grant_after = grant_o;
            if (err_o != 0 && k_err < 0) begin
                k_err   = k;
                err_val = err_o;
                req_i   = '0;
            end
        end
        chk("tmo cycle", k_err, 49);
        chk("tmo err winner", err_val, 3'b010);
        chk("tmo err count", errs[1], 1);
        chk("tmo no done", dones[0] + dones[1] + dones[2], 0);
        chk("tmo back to idle", grant_after, 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
